// File: rtl/spart_rx.sv
// spart_rx: SPART receive stage. Oversamples the asynchronous rxd line with
// the baud generator's enable tick, assembles 8N1 frames LSB first and hands
// each byte to the bus interface with ready/framing/overrun status.
//
// Ports:
//   clk          system clock, rising edge
//   rst          synchronous active-high reset
//   enable       single-cycle oversample tick (OVERSAMPLE ticks per bit)
//   rxd          asynchronous serial input, idles high
//   clr_rda      single-cycle acknowledge that the byte was read
//   rx_data      last received byte
//   rda          receive data available
//   framing_err  stop bit of the last frame was sampled low
//   overrun      a byte completed while rda was still set
module spart_rx #(
  parameter int unsigned OVERSAMPLE = 16,
  parameter int unsigned DATA_BITS  = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable,
  input  logic                 rxd,
  input  logic                 clr_rda,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rda,
  output logic                 framing_err,
  output logic                 overrun
);

  localparam int unsigned TW = $clog2(OVERSAMPLE);
  localparam int unsigned BW = $clog2(DATA_BITS + 1);

  localparam logic [TW-1:0] TC_HALF = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] TC_FULL = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] BC_LAST = BW'(DATA_BITS - 1);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] START = 3'd1;
  localparam logic [2:0] DATA  = 3'd2;
  localparam logic [2:0] STOP  = 3'd3;
  localparam logic [2:0] BRK   = 3'd4;

  logic                 rxd_meta, rxs;
  logic [2:0]           state, state_n;
  logic [TW-1:0]        tc, tc_n;
  logic [BW-1:0]        bc, bc_n;
  logic [DATA_BITS-1:0] shreg, shreg_n;
  logic [DATA_BITS-1:0] rx_data_n;
  logic                 rda_n, framing_err_n, overrun_n;

  // Two-flop synchronizer; resets to the idle (high) line level
  always_ff @(posedge clk) begin
    if (rst) begin
      rxd_meta <= 1'b1;
      rxs      <= 1'b1;
    end else begin
      rxd_meta <= rxd;
      rxs      <= rxd_meta;
    end
  end

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      tc          <= '0;
      bc          <= '0;
      shreg       <= '0;
      rx_data     <= '0;
      rda         <= 1'b0;
      framing_err <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      state       <= state_n;
      tc          <= tc_n;
      bc          <= bc_n;
      shreg       <= shreg_n;
      rx_data     <= rx_data_n;
      rda         <= rda_n;
      framing_err <= framing_err_n;
      overrun     <= overrun_n;
    end
  end

  // Next-state, counters, shift register and flags
  always_comb begin
    state_n       = state;
    tc_n          = tc;
    bc_n          = bc;
    shreg_n       = shreg;
    rx_data_n     = rx_data;
    rda_n         = rda;
    framing_err_n = framing_err;
    overrun_n     = overrun;

    // Acknowledge; a frame completion below overrides it
    if (clr_rda) begin
      rda_n     = 1'b0;
      overrun_n = 1'b0;
    end

    case (state)
      IDLE: begin
        tc_n = '0;
        bc_n = '0;
        if (!rxs) state_n = START;
      end

      // Re-check the line at mid start bit to reject glitches
      START: begin
        if (enable) begin
          if (tc == TC_HALF) begin
            tc_n    = '0;
            state_n = rxs ? IDLE : DATA;
          end else begin
            tc_n = tc + TW'(1);
          end
        end
      end

      // Right shift so the first (LSB) bit lands in bit 0
      DATA: begin
        if (enable) begin
          if (tc == TC_FULL) begin
            shreg_n = {rxs, shreg[DATA_BITS-1:1]};
            tc_n    = '0;
            bc_n    = bc + BW'(1);
            if (bc == BC_LAST) state_n = STOP;
          end else begin
            tc_n = tc + TW'(1);
          end
        end
      end

      // Frame completion at mid stop bit
      STOP: begin
        if (enable) begin
          if (tc == TC_FULL) begin
            tc_n          = '0;
            rx_data_n     = shreg;
            rda_n         = 1'b1;
            framing_err_n = !rxs;
            overrun_n     = (rda | overrun) & !clr_rda;
            state_n       = rxs ? IDLE : BRK;
          end else begin
            tc_n = tc + TW'(1);
          end
        end
      end

      // Held-low line: wait for it to return high before rearming
      BRK: begin
        tc_n = '0;
        bc_n = '0;
        if (rxs) state_n = IDLE;
      end

      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_spart_rx.sv
module tb_spart_rx;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       enable = 1'b0;
  logic       rxd = 1'b1;
  logic       clr_rda = 1'b0;
  logic [7:0] rx_data;
  logic       rda;
  logic       framing_err;
  logic       overrun;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int rise_at = 0;
  int lat = 0;
  int clr_at = 0;
  bit dropped = 1'b0;
  logic prev_rda = 1'b0;

  spart_rx #(.OVERSAMPLE(16), .DATA_BITS(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .enable      (enable),
    .rxd         (rxd),
    .clr_rda     (clr_rda),
    .rx_data     (rx_data),
    .rda         (rda),
    .framing_err (framing_err),
    .overrun     (overrun)
  );

  always #5 clk = ~clk;

  // Oversample tick every 2nd cycle: 32 clocks per bit
  initial begin
    forever begin
      @(negedge clk);
      enable = ~enable;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish, tests=%0d", tests);
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock; samples #1 after the edge and tracks rda edges
  task automatic tick();
    if (clr_at != 0) clr_rda = (cyc + 1 == clr_at);
    @(posedge clk);
    #1;
    cyc++;
    if (!prev_rda && rda && rise_at == 0) rise_at = cyc;
    if (prev_rda && !rda) dropped = 1'b1;
    prev_rda = rda;
  endtask

  task automatic drive_bit(input logic v);
    rxd = v;
    repeat (32) tick();
  endtask

  // Start each frame on the same enable phase so completion timing repeats
  task automatic align();
    int guard;
    guard = 0;
    while (enable !== 1'b1 && guard < 4) begin
      tick();
      guard++;
    end
    cyc      = 0;
    rise_at  = 0;
    dropped  = 1'b0;
    prev_rda = rda;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stopb);
    align();
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
    drive_bit(stopb);
  endtask

  task automatic pulse_clr();
    clr_rda = 1'b1;
    tick();
    clr_rda = 1'b0;
    tick();
  endtask

  initial begin
    // Reset
    rst = 1'b1;
    rxd = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    check("reset_rx_data", 32'(rx_data), 32'h00);
    check("reset_rda", 32'(rda), 32'd0);
    check("reset_ferr", 32'(framing_err), 32'd0);
    check("reset_overrun", 32'(overrun), 32'd0);
    repeat (5) tick();

    // Basic byte 0xDC
    send_frame(8'hDC, 1'b1);
    lat = rise_at;
    check("basic_latency_in_range", 32'(lat >= 304 && lat <= 308), 32'd1);
    check("basic_rx_data", 32'(rx_data), 32'hDC);
    check("basic_rda", 32'(rda), 32'd1);
    check("basic_ferr", 32'(framing_err), 32'd0);
    check("basic_overrun", 32'(overrun), 32'd0);
    pulse_clr();
    check("basic_clr_rda", 32'(rda), 32'd0);

    // Glitch rejection: 6 cycles low is shorter than half a bit
    rxd = 1'b0;
    repeat (6) tick();
    rxd = 1'b1;
    repeat (400) tick();
    check("glitch_rda", 32'(rda), 32'd0);
    check("glitch_rx_data", 32'(rx_data), 32'hDC);
    check("glitch_ferr", 32'(framing_err), 32'd0);

    // Framing error with line held low afterwards
    send_frame(8'h55, 1'b0);
    check("ferr_rx_data", 32'(rx_data), 32'h55);
    check("ferr_rda", 32'(rda), 32'd1);
    check("ferr_flag", 32'(framing_err), 32'd1);
    repeat (100) tick();
    rxd = 1'b1;
    repeat (400) tick();
    check("ferr_no_second_frame_data", 32'(rx_data), 32'h55);
    check("ferr_no_second_frame_ovr", 32'(overrun), 32'd0);
    check("ferr_rda_held", 32'(rda), 32'd1);
    pulse_clr();

    // Overrun: two bytes back to back, no acknowledge
    send_frame(8'h12, 1'b1);
    check("ovr_first_data", 32'(rx_data), 32'h12);
    check("ovr_first_no_overrun", 32'(overrun), 32'd0);
    send_frame(8'h34, 1'b1);
    check("ovr_rx_data", 32'(rx_data), 32'h34);
    check("ovr_overrun", 32'(overrun), 32'd1);
    check("ovr_rda", 32'(rda), 32'd1);
    check("ovr_ferr_cleared", 32'(framing_err), 32'd0);
    pulse_clr();
    check("ovr_clr_rda", 32'(rda), 32'd0);
    check("ovr_clr_overrun", 32'(overrun), 32'd0);
    repeat (10) tick();

    // Clear collision on the completion cycle of the second byte
    send_frame(8'h11, 1'b1);
    check("coll_first_data", 32'(rx_data), 32'h11);
    clr_at = lat;
    send_frame(8'hA5, 1'b1);
    clr_at  = 0;
    clr_rda = 1'b0;
    check("coll_rda", 32'(rda), 32'd1);
    check("coll_rx_data", 32'(rx_data), 32'hA5);
    check("coll_overrun", 32'(overrun), 32'd0);
    check("coll_rda_never_dropped", 32'(dropped), 32'd0);
    pulse_clr();
    repeat (10) tick();

    // Reset after the 4th data bit, then a clean 0x81 frame
    align();
    drive_bit(1'b0);
    drive_bit(1'b1);
    drive_bit(1'b1);
    drive_bit(1'b0);
    drive_bit(1'b1);
    rst = 1'b1;
    rxd = 1'b1;
    tick();
    rst = 1'b0;
    repeat (400) tick();
    check("rstmid_rda", 32'(rda), 32'd0);
    check("rstmid_rx_data", 32'(rx_data), 32'h00);
    check("rstmid_overrun", 32'(overrun), 32'd0);
    send_frame(8'h81, 1'b1);
    check("rstmid_new_rx_data", 32'(rx_data), 32'h81);
    check("rstmid_new_rda", 32'(rda), 32'd1);
    check("rstmid_new_ferr", 32'(framing_err), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
